mem_bus_arbiter: RTL and testbench

//  Shares one external memory bus between the IF-stage instruction-fetch port and the MEM-stage data port.

---
 rtl/mem_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one req/ack memory bus between the data port (priority) and the fetch port,
// with a burst counter that caps how long a waiting fetch can be starved.
module mem_bus_arbiter #(
    parameter int unsigned MAX_D_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_re,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_mask,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    input  logic        i_re,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        flush,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_mask,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        stall_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUS_D  = 3'd1,
        BUS_I  = 3'd2,
        DONE_D = 3'd3,
        DONE_I = 3'd4
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_D_BURST);

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_mask_q, bus_mask_d;
    logic [31:0] hold_q, hold_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        flush_seen_q, flush_seen_d;
    logic        d_pend;

    assign d_pend = d_re | d_we;

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_mask_d   = bus_mask_q;
        hold_d       = hold_q;
        cnt_d        = cnt_q;
        flush_seen_d = flush_seen_q;
        case (state_q)
            IDLE: begin
                if (d_pend && (!i_re || (cnt_q < MAX_CNT))) begin
                    state_d     = BUS_D;
                    bus_req_d   = 1'b1;
                    bus_we_d    = d_we;
                    bus_addr_d  = d_addr;
                    bus_wdata_d = d_wdata;
                    bus_mask_d  = d_mask;
                    if (i_re)
                        cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 4'd1;
                    else
                        cnt_d = 4'd0;
                end else if (i_re && !flush) begin
                    state_d      = BUS_I;
                    bus_req_d    = 1'b1;
                    bus_we_d     = 1'b0;
                    bus_addr_d   = i_addr;
                    bus_wdata_d  = 32'd0;
                    bus_mask_d   = 4'b1111;
                    cnt_d        = 4'd0;
                    flush_seen_d = 1'b0;
                end
            end
            BUS_D: begin
                if (bus_ack) begin
                    state_d   = DONE_D;
                    bus_req_d = 1'b0;
                    hold_d    = bus_rdata;
                end
            end
            BUS_I: begin
                // A flush anywhere in the access cancels its completion, even in the ack cycle
                flush_seen_d = flush_seen_q | flush;
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    hold_d    = bus_rdata;
                    state_d   = (flush_seen_q | flush) ? IDLE : DONE_I;
                end
            end
            DONE_D, DONE_I: state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'd0;
            bus_wdata_q  <= 32'd0;
            bus_mask_q   <= 4'd0;
            hold_q       <= 32'd0;
            cnt_q        <= 4'd0;
            flush_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_mask_q   <= bus_mask_d;
            hold_q       <= hold_d;
            cnt_q        <= cnt_d;
            flush_seen_q <= flush_seen_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_mask  = bus_mask_q;
    assign d_rdata   = hold_q;
    assign i_rdata   = hold_q;
    assign d_ready   = (state_q == DONE_D);
    assign i_ready   = (state_q == DONE_I) && !flush;
    assign stall_o   = (d_pend | (i_re & ~flush)) & ~(d_ready | i_ready);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: each task drives one scenario and checks outputs 1ns after the clock edge.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_re, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_mask;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        i_re;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        flush;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_mask;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        stall_o;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.MAX_D_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .i_re(i_re), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .flush(flush),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_mask(bus_mask), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .stall_o(stall_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; d_re = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_mask = 0;
        i_re = 0; i_addr = 0; flush = 0; bus_rdata = 0; bus_ack = 0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (bus_req !== 1'b0) $display("FAIL rst_bus_req: got %b want 0", bus_req); else passes++;
        checks++; if (d_ready !== 1'b0 || i_ready !== 1'b0) $display("FAIL rst_ready: got d=%b i=%b want 0", d_ready, i_ready); else passes++;
        checks++; if (d_rdata !== 32'h0 || i_rdata !== 32'h0) $display("FAIL rst_rdata: got %h/%h want 0", d_rdata, i_rdata); else passes++;
        checks++; if (bus_addr !== 32'h0 || bus_mask !== 4'h0 || bus_we !== 1'b0) $display("FAIL rst_bus: got %h %h %b want 0", bus_addr, bus_mask, bus_we); else passes++;
        checks++; if (stall_o !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall_o); else passes++;
        d_re = 1; d_addr = 32'h80400000; d_mask = 4'hF;
        tick();
        checks++; if (bus_req !== 1'b1) $display("FAIL rst_grant: got %b want 1", bus_req); else passes++;
        rst = 1'b1;
        tick();
        checks++; if (bus_req !== 1'b0) $display("FAIL rst_mid_bus_req: got %b want 0", bus_req); else passes++;
        checks++; if (d_ready !== 1'b0) $display("FAIL rst_mid_d_ready: got %b want 0", d_ready); else passes++;
        checks++; if (stall_o !== 1'b1) $display("FAIL rst_mid_stall: got %b want 1", stall_o); else passes++;
        d_re = 0;
        #1;
        checks++; if (stall_o !== 1'b0) $display("FAIL rst_stall_follow: got %b want 0", stall_o); else passes++;
        rst = 1'b0;
        tick();
        $display("reset: in-flight data access aborted");
    endtask

    task automatic test_fetch_only();
        reset_dut();
        i_re = 1; i_addr = 32'h80000000;
        tick();
        checks++; if (bus_req !== 1'b1 || bus_we !== 1'b0) $display("FAIL fetch_req: got req=%b we=%b want 1/0", bus_req, bus_we); else passes++;
        checks++; if (bus_addr !== 32'h80000000) $display("FAIL fetch_addr: got %h want 80000000", bus_addr); else passes++;
        checks++; if (bus_mask !== 4'b1111) $display("FAIL fetch_mask: got %b want 1111", bus_mask); else passes++;
        checks++; if (stall_o !== 1'b1) $display("FAIL fetch_stall: got %b want 1", stall_o); else passes++;
        tick();
        checks++; if (bus_req !== 1'b1 || i_ready !== 1'b0) $display("FAIL fetch_wait: got req=%b rdy=%b want 1/0", bus_req, i_ready); else passes++;
        bus_ack = 1; bus_rdata = 32'h24080001;
        tick();
        bus_ack = 0;
        checks++; if (i_ready !== 1'b1 || i_rdata !== 32'h24080001) $display("FAIL fetch_ready: got rdy=%b data=%h want 1/24080001", i_ready, i_rdata); else passes++;
        checks++; if (bus_req !== 1'b0 || stall_o !== 1'b0) $display("FAIL fetch_release: got req=%b stall=%b want 0/0", bus_req, stall_o); else passes++;
        i_re = 0;
        tick();
        checks++; if (i_ready !== 1'b0 || i_rdata !== 32'h24080001) $display("FAIL fetch_pulse: got rdy=%b data=%h want 0/24080001", i_ready, i_rdata); else passes++;
        $display("fetch: addr=80000000 data=%h", i_rdata);
    endtask

    task automatic test_collision();
        reset_dut();
        d_re = 1; d_addr = 32'h80400004; d_mask = 4'b0011;
        i_re = 1; i_addr = 32'h80000010;
        tick();
        checks++; if (bus_addr !== 32'h80400004 || bus_mask !== 4'b0011 || bus_we !== 1'b0) $display("FAIL coll_first: got %h %b %b want 80400004 0011 0", bus_addr, bus_mask, bus_we); else passes++;
        bus_ack = 1; bus_rdata = 32'h11112222;
        tick();
        bus_ack = 0;
        checks++; if (d_ready !== 1'b1 || i_ready !== 1'b0 || d_rdata !== 32'h11112222) $display("FAIL coll_d_done: got d=%b i=%b data=%h want 1/0/11112222", d_ready, i_ready, d_rdata); else passes++;
        d_re = 0;
        tick();
        checks++; if (bus_req !== 1'b0 || stall_o !== 1'b1) $display("FAIL coll_idle: got req=%b stall=%b want 0/1", bus_req, stall_o); else passes++;
        tick();
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h80000010 || bus_mask !== 4'b1111) $display("FAIL coll_second: got %b %h %b want 1 80000010 1111", bus_req, bus_addr, bus_mask); else passes++;
        bus_ack = 1; bus_rdata = 32'h33334444;
        tick();
        bus_ack = 0;
        checks++; if (i_ready !== 1'b1 || i_rdata !== 32'h33334444) $display("FAIL coll_i_done: got %b %h want 1/33334444", i_ready, i_rdata); else passes++;
        i_re = 0;
        tick();
        $display("collision: data 80400004 then fetch 80000010");
    endtask

    task automatic test_starvation();
        reset_dut();
        d_we = 1; d_addr = 32'h80400100; d_wdata = 32'h01020304; d_mask = 4'hF;
        i_re = 1; i_addr = 32'h80000040;
        for (int g = 1; g <= 5; g++) begin
            tick();
            checks++;
            if (bus_req !== 1'b1 || bus_we !== (g <= 4) || bus_addr !== ((g <= 4) ? 32'h80400100 : 32'h80000040))
                $display("FAIL starve_grant%0d: got req=%b we=%b addr=%h want we=%b", g, bus_req, bus_we, bus_addr, (g <= 4));
            else passes++;
            bus_ack = 1; bus_rdata = 32'h00000100 + g;
            tick();
            bus_ack = 0;
            checks++;
            if (d_ready !== (g <= 4) || i_ready !== (g == 5))
                $display("FAIL starve_ready%0d: got d=%b i=%b", g, d_ready, i_ready);
            else passes++;
            if (g == 5) i_re = 0;
            $display("starvation: grant %0d to %s", g, (g <= 4) ? "data" : "fetch");
            tick();
        end
        checks++; if (dut.cnt_q !== 4'd0) $display("FAIL starve_cnt: got %0d want 0", dut.cnt_q); else passes++;
        i_re = 1;
        tick();
        checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1) $display("FAIL starve_regrant: got req=%b we=%b want 1/1", bus_req, bus_we); else passes++;
    endtask

    task automatic test_flush();
        reset_dut();
        i_re = 1; i_addr = 32'h80000020;
        tick();
        checks++; if (bus_req !== 1'b1) $display("FAIL flush_grant: got %b want 1", bus_req); else passes++;
        flush = 1;
        tick();
        flush = 0; i_re = 0;
        checks++; if (bus_req !== 1'b1) $display("FAIL flush_hold1: got %b want 1", bus_req); else passes++;
        tick();
        checks++; if (bus_req !== 1'b1) $display("FAIL flush_hold2: got %b want 1", bus_req); else passes++;
        bus_ack = 1; bus_rdata = 32'hDEADBEEF;
        tick();
        bus_ack = 0;
        checks++; if (bus_req !== 1'b0 || i_ready !== 1'b0) $display("FAIL flush_ack: got req=%b rdy=%b want 0/0", bus_req, i_ready); else passes++;
        d_re = 1; d_addr = 32'h80400010; d_mask = 4'hF;
        tick();
        checks++; if (i_ready !== 1'b0 || bus_req !== 1'b1 || bus_addr !== 32'h80400010) $display("FAIL flush_idle: got rdy=%b req=%b addr=%h want 0/1/80400010", i_ready, bus_req, bus_addr); else passes++;
        $display("flush: cancelled fetch 80000020, back in IDLE");
        reset_dut();
        i_re = 1; flush = 1;
        tick();
        checks++; if (bus_req !== 1'b0 || stall_o !== 1'b0) $display("FAIL flush_idle_nogrant: got req=%b stall=%b want 0/0", bus_req, stall_o); else passes++;
        d_re = 1; d_addr = 32'h80400020;
        tick();
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h80400020) $display("FAIL flush_data_grant: got req=%b addr=%h want 1/80400020", bus_req, bus_addr); else passes++;
        $display("flush: idle fetch blocked, data granted");
    endtask

    task automatic test_write();
        reset_dut();
        d_we = 1; d_addr = 32'h80400008; d_wdata = 32'hA5A5A5A5; d_mask = 4'b0100;
        tick();
        checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1) $display("FAIL wr_req: got req=%b we=%b want 1/1", bus_req, bus_we); else passes++;
        checks++; if (bus_wdata !== 32'hA5A5A5A5 || bus_mask !== 4'b0100 || bus_addr !== 32'h80400008) $display("FAIL wr_bus: got %h %b %h", bus_wdata, bus_mask, bus_addr); else passes++;
        d_wdata = 32'h0; d_mask = 4'h0;
        tick();
        checks++; if (bus_wdata !== 32'hA5A5A5A5 || bus_mask !== 4'b0100 || d_ready !== 1'b0) $display("FAIL wr_stable: got %h %b rdy=%b", bus_wdata, bus_mask, d_ready); else passes++;
        bus_ack = 1;
        tick();
        bus_ack = 0;
        checks++; if (d_ready !== 1'b1 || bus_req !== 1'b0) $display("FAIL wr_done: got rdy=%b req=%b want 1/0", d_ready, bus_req); else passes++;
        d_we = 0;
        tick();
        checks++; if (d_ready !== 1'b0) $display("FAIL wr_pulse: got %b want 0", d_ready); else passes++;
        $display("write: addr=80400008 data=a5a5a5a5 mask=0100");
        reset_dut();
        d_re = 1; d_we = 1; d_addr = 32'h80400030; d_mask = 4'hF;
        tick();
        checks++; if (bus_we !== 1'b1) $display("FAIL rw_both_is_write: got %b want 1", bus_we); else passes++;
        $display("read+write: treated as write");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch_only();
        test_collision();
        test_starvation();
        test_flush();
        test_write();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
